// File: rtl/grant_sched_pkg.sv
// Shared types and constants for the grant request scheduler and its downstream grant FSM.
package grant_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 8;

    // Encodings of the downstream 4-state request/grant FSM.
    typedef enum logic [1:0] {
        DS_IDLE    = 2'b00,
        DS_REQ     = 2'b01,
        DS_BUSY    = 2'b10,
        DS_GRANTED = 2'b11
    } ds_state_e;

    function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest pending index is assigned last.
    always_comb begin
        valid  = |pending;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
            if (pending[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/grant_req_scheduler.sv
// Round-robin front-end issuing one request at a time to the downstream grant FSM.
// Optional grant timeout is enabled by defining GRANT_TIMEOUT_EN.
module grant_req_scheduler
    import grant_sched_pkg::*;
#(
    parameter int unsigned  NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               ds_request,
    input  logic               ds_idle,
    input  logic               ds_granted,
    output logic               busy,
    output logic [ID_W-1:0]    cur_id,
    output logic [NUM_REQ-1:0] pending_o,
    output logic               timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    sched_state_e       state;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] cur_onehot;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;
    logic               grant_hit;
    logic               expire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .valid   (pick_valid),
        .winner  (pick_id)
    );

    always_comb begin
        cur_onehot         = '0;
        cur_onehot[cur_id] = 1'b1;
    end

    assign grant_hit = (state == S_WAIT) && ds_granted;
    assign clr       = grant_hit ? cur_onehot : '0;

`ifdef GRANT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Expires on the last allowed S_WAIT cycle; a same-cycle grant takes precedence.
    assign expire = (state == S_WAIT) && !ds_granted && (wait_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                wait_cnt <= CNT_W'(TIMEOUT_CYCLES);
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pending <= '0;
            rr_ptr  <= '0;
            cur_id  <= '0;
            ack_o   <= '0;
        end else begin
            // A new pulse on the client being cleared keeps it pending.
            pending <= (pending & ~clr) | req_i;
            ack_o   <= clr;
            case (state)
                S_IDLE: begin
                    if (pick_valid && ds_idle) begin
                        cur_id <= pick_id;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ds_granted) begin
                        rr_ptr <= ID_W'(rr_next(32'(cur_id), NUM_REQ));
                        state  <= S_DONE;
                    end else if (expire) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (ds_idle) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ds_request = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign pending_o  = pending;

endmodule

// File: tb/tb_grant_req_scheduler.sv
// Self-checking bench for grant_req_scheduler with a cycle-accurate downstream grant FSM model.
module tb_grant_req_scheduler;
    import grant_sched_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [3:0]  req;
        int          n;
        logic [15:0] acks;
    } vec_t;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b0;
    logic [N-1:0] req_i      = '0;
    logic [N-1:0] ack_o;
    logic [N-1:0] pending_o;
    logic         ds_request;
    logic         ds_idle;
    logic         ds_granted;
    logic         busy;
    logic         timeout_err;
    logic [1:0]   cur_id;
    ds_state_e    ds_st      = DS_IDLE;
    logic         hold_grant = 1'b0;
    logic         block_idle = 1'b0;
    int           total      = 0;
    int           bad        = 0;
    int           cyc        = 0;
    vec_t         vecs [7];

    grant_req_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_i),
        .ack_o       (ack_o),
        .ds_request  (ds_request),
        .ds_idle     (ds_idle),
        .ds_granted  (ds_granted),
        .busy        (busy),
        .cur_id      (cur_id),
        .pending_o   (pending_o),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Downstream model: request -> REQ -> BUSY -> GRANTED (3 cycles) -> IDLE.
    assign ds_idle    = (ds_st == DS_IDLE) && !block_idle;
    assign ds_granted = (ds_st == DS_GRANTED);

    always @(posedge clk) begin
        case (ds_st)
            DS_IDLE: if (ds_request === 1'b1) ds_st <= DS_REQ;
            DS_REQ:  ds_st <= DS_BUSY;
            DS_BUSY: if (!hold_grant) ds_st <= DS_GRANTED;
            default: ds_st <= DS_IDLE;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_acks(input string name, input int n, input logic [15:0] exp_acks,
                            input int nreq0);
        int k    = 0;
        int last = -1;
        int nreq = nreq0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (ds_request) nreq++;
            if (ack_o != '0) begin
                if (k < n) check({name, " ack"}, 32'(ack_o), 32'(exp_acks[4*k +: 4]));
                else check({name, " extra ack"}, 32'(ack_o), 32'(0));
                if (last >= 0) check({name, " ack spacing"}, 32'(cyc - last), 32'(6));
                last = cyc;
                k++;
            end
            if (k >= n && !busy) break;
        end
        check({name, " ack count"}, 32'(k), 32'(n));
        check({name, " ds_request count"}, 32'(nreq), 32'(n));
        check({name, " pending drained"}, 32'(pending_o), 32'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, rel, req_cyc, nreq, ack_cyc, k, cnt_req, cnt_ack, creq, terr;
        logic [3:0]  ack_val;
        logic [15:0] exp3;
        logic        pulsed, just;

        vecs[0] = '{4'b1111, 4, 16'h8421};
        vecs[1] = '{4'b0001, 1, 16'h0001};
        vecs[2] = '{4'b0101, 2, 16'h0014};
        vecs[3] = '{4'b1001, 2, 16'h0018};
        vecs[4] = '{4'b0010, 1, 16'h0002};
        vecs[5] = '{4'b0011, 2, 16'h0021};
        vecs[6] = '{4'b1000, 1, 16'h0008};

        // Reset state
        do_reset();
        check("reset ack_o", 32'(ack_o), 32'(0));
        check("reset ds_request", 32'(ds_request), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset pending", 32'(pending_o), 32'(0));
        check("reset cur_id", 32'(cur_id), 32'(0));
        check("reset timeout_err", 32'(timeout_err), 32'(0));

        // 1: single request latency
        req_i = 4'b0001;
        c0 = cyc;
        req_cyc = -1; nreq = 0; ack_cyc = -1; ack_val = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            req_i = '0;
            rel = cyc - c0;
            if (ds_request) begin
                nreq++;
                if (req_cyc < 0) req_cyc = rel;
            end
            if (ack_o != '0 && ack_cyc < 0) begin
                ack_cyc = rel;
                ack_val = ack_o;
            end
            if (rel == 1) check("t1 pending set", 32'(pending_o), 32'(4'b0001));
            if (rel == 2) check("t1 busy in issue", 32'(busy), 32'(1));
            if (rel == 6) check("t1 pending cleared", 32'(pending_o), 32'(0));
            if (rel == 7) check("t1 busy low", 32'(busy), 32'(0));
        end
        check("t1 ds_request cycle", 32'(req_cyc), 32'(2));
        check("t1 ds_request count", 32'(nreq), 32'(1));
        check("t1 ack cycle", 32'(ack_cyc), 32'(6));
        check("t1 ack value", 32'(ack_val), 32'(4'b0001));

        // 2 + table: round-robin order from rr_ptr=0
        do_reset();
        for (int v = 0; v < 7; v++) begin
            req_i = vecs[v].req;
            step();
            req_i = '0;
            check($sformatf("vec%0d pending", v), 32'(pending_o), 32'(vecs[v].req));
            run_acks($sformatf("vec%0d", v), vecs[v].n, vecs[v].acks, 0);
        end

        // 3: client 2 re-pulses in its clear cycle; rr_ptr is 0 here
        exp3 = 16'h4841;
        req_i = 4'b0101;
        step();
        req_i = '0;
        pulsed = 1'b0;
        k = 0;
        for (int c = 0; c < 80; c++) begin
            just = 1'b0;
            if (!pulsed && ds_granted && busy && cur_id == 2'd2) begin
                req_i  = 4'b1100;
                pulsed = 1'b1;
                just   = 1'b1;
            end
            step();
            req_i = '0;
            if (just) check("t3 set wins over clear", 32'(pending_o), 32'(4'b1100));
            if (ack_o != '0) begin
                if (k < 4) check("t3 ack order", 32'(ack_o), 32'(exp3[4*k +: 4]));
                else check("t3 extra ack", 32'(ack_o), 32'(0));
                k++;
            end
            if (k >= 4 && !busy) break;
        end
        check("t3 ack count", 32'(k), 32'(4));

        // 4: ds_idle held low blocks issue
        block_idle = 1'b1;
        req_i = 4'b0010;
        step();
        req_i = '0;
        cnt_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ds_request) cnt_req++;
        end
        check("t4 no issue while not idle", 32'(cnt_req), 32'(0));
        check("t4 pending held", 32'(pending_o), 32'(4'b0010));
        check("t4 busy low", 32'(busy), 32'(0));
        block_idle = 1'b0;
        step();
        check("t4 issue after release", 32'(ds_request), 32'(1));
        run_acks("t4", 1, 16'h0002, 1);

        // 5: reset while in S_WAIT
        req_i = 4'b0100;
        step();
        req_i = '0;
        for (int i = 0; i < 10 && !ds_request; i++) step();
        check("t5 issued", 32'(ds_request), 32'(1));
        step();
        check("t5 cur_id before reset", 32'(cur_id), 32'(2));
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("t5 ack after reset", 32'(ack_o), 32'(0));
        check("t5 ds_request after reset", 32'(ds_request), 32'(0));
        check("t5 busy after reset", 32'(busy), 32'(0));
        check("t5 pending after reset", 32'(pending_o), 32'(0));
        check("t5 cur_id after reset", 32'(cur_id), 32'(0));
        check("t5 timeout_err after reset", 32'(timeout_err), 32'(0));
        cnt_ack = 0;
        cnt_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack_o != '0) cnt_ack++;
            if (ds_request) cnt_req++;
        end
        check("t5 late grant gives no ack", 32'(cnt_ack), 32'(0));
        check("t5 no reissue", 32'(cnt_req), 32'(0));

        // 6: downstream never grants
        hold_grant = 1'b1;
        req_i = 4'b0001;
        step();
        req_i = '0;
`ifdef GRANT_TIMEOUT_EN
        creq = -1;
        terr = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ds_request && creq < 0) creq = cyc;
            if (timeout_err && terr < 0) begin
                terr = cyc;
                check("t6 pending kept", 32'(pending_o), 32'(4'b0001));
                check("t6 back to idle", 32'(busy), 32'(0));
                break;
            end
        end
        check("t6 timeout latency", 32'(terr - creq), 32'(9));
        hold_grant = 1'b0;
        run_acks("t6 retry", 1, 16'h0001, 0);
        check("t6 timeout_err sticky", 32'(timeout_err), 32'(1));
`else
        creq = 0;
        terr = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ds_request) creq++;
            if (timeout_err) terr++;
        end
        check("t6 single issue", 32'(creq), 32'(1));
        check("t6 timeout_err stays low", 32'(terr), 32'(0));
        check("t6 busy held", 32'(busy), 32'(1));
        hold_grant = 1'b0;
        run_acks("t6 release", 1, 16'h0001, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
